// File: rtl/bram_shr_sequencer.sv
// Serialises BRAM test vectors into the ROI shift-register harness
// and deserialises the ROI output captured at each strobe.
module bram_shr_sequencer #(
  parameter int DIN_N  = 160,
  parameter int DOUT_N = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DIN_N-1:0]  vec_data,
  output logic              res_valid,
  output logic [DOUT_N-1:0] res_data,
  output logic              res_first,
  output logic              di,
  output logic              stb,
  input  logic              do_in,
  output logic              busy
);

  localparam int BW   = $clog2(DIN_N);
  localparam int CW   = $clog2(DOUT_N + 1);
  localparam int CAPW = (DOUT_N > 1) ? DOUT_N - 1 : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(DIN_N - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(DOUT_N - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DIN_N-1:0]  sreg_q, sreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              di_q, di_d;
  logic              stb_q, stb_d;

  logic              cpend_q, cpend_d;
  logic [CW-1:0]     capcnt_q, capcnt_d;
  logic [CAPW-1:0]   cap_q, cap_d;
  logic [DOUT_N-1:0] cap_nxt;
  logic [DOUT_N-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              rfirst_q, rfirst_d;
  logic              first_q, first_d;

  logic              xfer;
  logic              arm;
  logic              cap_done;

  assign vec_ready = (state_q != SHIFT);
  assign busy      = (state_q != IDLE);
  assign xfer      = vec_valid && vec_ready;
  assign cap_done  = cpend_q && (capcnt_q == CAP_LAST);

  assign di        = di_q;
  assign stb       = stb_q;
  assign res_valid = rvalid_q;
  assign res_data  = rdata_q;
  assign res_first = rfirst_q;

  // Bits already captured, with the current do_in appended as LSB.
  if (DOUT_N > 1) begin : g_wide
    assign cap_nxt = {cap_q, do_in};
  end else begin : g_one
    assign cap_nxt = do_in;
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    di_d     = 1'b0;
    stb_d    = 1'b0;
    arm      = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        if (bitcnt_q == BIT_LAST) begin
          state_d = STROBE;
          stb_d   = 1'b1;
        end else begin
          di_d     = sreg_q[DIN_N-1];
          sreg_d   = sreg_q << 1;
          bitcnt_d = bitcnt_q + BW'(1);
        end
      end
      STROBE: begin
        arm     = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (cap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new vector can only arrive outside SHIFT and always wins.
    if (xfer) begin
      state_d  = SHIFT;
      bitcnt_d = '0;
      di_d     = vec_data[DIN_N-1];
      sreg_d   = vec_data << 1;
    end
  end

  always_comb begin
    cpend_d  = cpend_q;
    capcnt_d = capcnt_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    first_d  = first_q;
    rvalid_d = cap_done;
    rfirst_d = cap_done && first_q;
    if (arm) begin
      cpend_d  = 1'b1;
      capcnt_d = '0;
    end else if (cpend_q) begin
      cap_d    = cap_nxt[CAPW-1:0];
      capcnt_d = capcnt_q + CW'(1);
      if (cap_done) begin
        cpend_d = 1'b0;
        rdata_d = cap_nxt;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      di_q     <= 1'b0;
      stb_q    <= 1'b0;
      cpend_q  <= 1'b0;
      capcnt_q <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rfirst_q <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      di_q     <= di_d;
      stb_q    <= stb_d;
      cpend_q  <= cpend_d;
      capcnt_q <= capcnt_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rfirst_q <= rfirst_d;
      first_q  <= first_d;
    end
  end

endmodule

// File: tb/tb_bram_shr_sequencer.sv
// Checks bram_shr_sequencer (8/8 and 8/4) against a timeline model
// with each instance driving an identity-ROI shift-register harness.
module tb_bram_shr_sequencer;

  localparam int DIN = 8;
  localparam int DA  = 8;
  localparam int DB  = 4;
  localparam int NC  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vec_valid;
  logic [7:0] vec_data;

  logic       rdy_a, rv_a, rf_a, di_a, stb_a, do_a, busy_a;
  logic [7:0] rd_a;
  logic       rdy_b, rv_b, rf_b, di_b, stb_b, do_b, busy_b;
  logic [3:0] rd_b;

  bram_shr_sequencer #(.DIN_N(DIN), .DOUT_N(DA)) u_a (
    .clk(clk), .rst_n(rst_n),
    .vec_valid(vec_valid), .vec_ready(rdy_a), .vec_data(vec_data),
    .res_valid(rv_a), .res_data(rd_a), .res_first(rf_a),
    .di(di_a), .stb(stb_a), .do_in(do_a), .busy(busy_a)
  );

  bram_shr_sequencer #(.DIN_N(DIN), .DOUT_N(DB)) u_b (
    .clk(clk), .rst_n(rst_n),
    .vec_valid(vec_valid), .vec_ready(rdy_b), .vec_data(vec_data),
    .res_valid(rv_b), .res_data(rd_b), .res_first(rf_b),
    .di(di_b), .stb(stb_b), .do_in(do_b), .busy(busy_b)
  );

  // Harness models: never reset, identity ROI between din and dout.
  logic [7:0] hin_a = '0, roi_a = '0, hout_a = '0;
  logic [7:0] hin_b = '0, roi_b = '0;
  logic [3:0] hout_b = '0;

  always @(posedge clk) begin
    hin_a <= {hin_a[6:0], di_a};
    if (stb_a) begin
      roi_a  <= hin_a;
      hout_a <= roi_a;
    end else begin
      hout_a <= hout_a << 1;
    end
    hin_b <= {hin_b[6:0], di_b};
    if (stb_b) begin
      roi_b  <= hin_b;
      hout_b <= roi_b[7:4];
    end else begin
      hout_b <= hout_b << 1;
    end
  end

  assign do_a = hout_a[7];
  assign do_b = hout_b[3];

  int n_chk = 0;
  int n_fail = 0;
  int c = 0;
  int shift_end = -1;
  int last_stb = -1;
  logic [7:0] prev = '0;
  logic [7:0] prev_before = '0;
  bit first_a = 1'b1;
  bit first_b = 1'b1;
  logic [7:0] hold_a = '0;
  logic [3:0] hold_b = '0;

  bit di_e[NC], stb_e[NC];
  bit busy_ae[NC], busy_be[NC];
  bit rv_ae[NC], rv_be[NC], rf_ae[NC], rf_be[NC];
  logic [7:0] rd_ae[NC];
  logic [3:0] rd_be[NC];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready_a"}, rdy_a, 1);
    chk({tag, "_ready_b"}, rdy_b, 1);
    chk({tag, "_di_a"}, di_a, 0);
    chk({tag, "_di_b"}, di_b, 0);
    chk({tag, "_stb_a"}, stb_a, 0);
    chk({tag, "_stb_b"}, stb_b, 0);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_busy_b"}, busy_b, 0);
    chk({tag, "_rv_a"}, rv_a, 0);
    chk({tag, "_rv_b"}, rv_b, 0);
    chk({tag, "_rf_a"}, rf_a, 0);
    chk({tag, "_rf_b"}, rf_b, 0);
    chk({tag, "_rd_a"}, rd_a, 0);
    chk({tag, "_rd_b"}, rd_b, 0);
  endtask

  // Accepted at cycle c: bits in c+1..c+DIN, strobe next, result after.
  task automatic schedule(input logic [7:0] v);
    for (int i = 0; i < DIN; i++) di_e[c+1+i] = v[DIN-1-i];
    stb_e[c+DIN+1] = 1'b1;
    for (int k = c + 1; k <= c + DIN + 1 + DA; k++) busy_ae[k] = 1'b1;
    for (int k = c + 1; k <= c + DIN + 1 + DB; k++) busy_be[k] = 1'b1;
    rv_ae[c+DIN+2+DA] = 1'b1;
    rd_ae[c+DIN+2+DA] = prev;
    rf_ae[c+DIN+2+DA] = first_a;
    rv_be[c+DIN+2+DB] = 1'b1;
    rd_be[c+DIN+2+DB] = prev[7:4];
    rf_be[c+DIN+2+DB] = first_b;
    first_a = 1'b0;
    first_b = 1'b0;
    prev_before = prev;
    prev = v;
    last_stb = c + DIN + 1;
    shift_end = c + DIN;
  endtask

  task automatic tick(output bit x);
    bit rdy;
    rdy = (c > shift_end);
    x = vec_valid && rdy;
    chk("ready_a", rdy_a, rdy);
    chk("ready_b", rdy_b, rdy);
    chk("di_a", di_a, di_e[c]);
    chk("di_b", di_b, di_e[c]);
    chk("stb_a", stb_a, stb_e[c]);
    chk("stb_b", stb_b, stb_e[c]);
    chk("busy_a", busy_a, busy_ae[c]);
    chk("busy_b", busy_b, busy_be[c]);
    chk("rvalid_a", rv_a, rv_ae[c]);
    chk("rvalid_b", rv_b, rv_be[c]);
    if (rv_ae[c]) begin
      hold_a = rd_ae[c];
      chk("first_a", rf_a, rf_ae[c]);
    end
    if (rv_be[c]) begin
      hold_b = rd_be[c];
      chk("first_b", rf_b, rf_be[c]);
    end
    chk("rdata_a", rd_a, hold_a);
    chk("rdata_b", rd_b, hold_b);
    if (x) schedule(vec_data);
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask

  task automatic idle(input int n);
    bit x;
    vec_valid = 1'b0;
    repeat (n) tick(x);
  endtask

  task automatic send(input logic [7:0] v);
    bit got;
    got = 1'b0;
    vec_valid = 1'b1;
    vec_data = v;
    for (int k = 0; k < 20 && !got; k++) tick(got);
    chk("accept", got, 1);
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    vec_valid = 1'b0;
    #1;
    chk_reset("async");
    for (int k = c; k < NC; k++) begin
      di_e[k] = 0; stb_e[k] = 0; busy_ae[k] = 0; busy_be[k] = 0;
      rv_ae[k] = 0; rv_be[k] = 0; rf_ae[k] = 0; rf_be[k] = 0;
    end
    if (c <= last_stb) prev = prev_before;
    first_a = 1'b1;
    first_b = 1'b1;
    hold_a = '0;
    hold_b = '0;
    shift_end = -1;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    chk_reset("held");
    rst_n = 1'b1;
  endtask

  initial begin
    bit x;
    rst_n = 1'b0;
    vec_valid = 1'b0;
    vec_data = '0;
    @(negedge clk);
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    // single vector after reset
    send(8'hA5);
    idle(25);
    // back-to-back with valid held high
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    idle(25);
    // late offer in the third drain cycle
    send(8'hA5);
    idle(11);
    send(8'h3C);
    idle(25);
    // offer in the drain cycle where the 8-bit capture completes
    send(8'hA5);
    idle(16);
    send(8'h3C);
    idle(25);
    // offer in the cycle where the 4-bit capture completes
    send(8'h96);
    idle(12);
    send(8'h3C);
    idle(25);
    // reset in the middle of shifting
    send(8'h5A);
    idle(3);
    apply_reset(2);
    idle(2);
    send(8'h11);
    idle(25);
    // narrow capture sees top nibble
    send(8'hF0);
    send(8'h00);
    idle(25);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      vec_valid = ($urandom_range(0, 2) != 0);
      vec_data = 8'($urandom);
      tick(x);
    end
    idle(25);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_shr_sequencer.md
Name: bram_shr_sequencer

Overview:
Drives the serial shift-register harness that wraps a BRAM ROI. The harness has four ports: clk, stb, di and do. The block takes parallel test vectors over a valid/ready handshake and serialises each one onto di. It then issues the stb pulse that loads the vector into the ROI and captures the ROI output, and deserialises do back into a parallel result word. It sits between a vector source (ROM or JTAG mailbox) and the harness top, sequencing BRAM stimulus vectors back-to-back.

Parameters:
DIN_N, 160, harness input shift-register length in bits (>=2)
DOUT_N, 160, harness output shift-register length in bits (1..DIN_N)

Ports:
clk  in  1  single clock, shared with the harness
rst_n  in  1  asynchronous, active-low reset
vec_valid  in  1  vector offered
vec_ready  out  1  block accepts vector this cycle
vec_data  in  DIN_N  vector to apply to the ROI
res_valid  out  1  one-cycle pulse; res_data valid
res_data  out  DOUT_N  ROI output captured at a strobe
res_first  out  1  qualifies res_valid: first result since reset (stale harness state)
di  out  1  serial data to harness (registered)
stb  out  1  load/capture strobe to harness (registered)
do_in  in  1  serial data from harness
busy  out  1  state != IDLE

Behaviour:
- Interface rule: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; di=0, stb=0, vec_ready=1, res_valid=0, res_first=0, res_data=0, busy=0. Capture pending and counters are cleared. A first-result flag is set.
- Reset mid-operation aborts the sequence. Harness contents are then undefined; the next result is flagged res_first.
- Handshake: a transfer occurs when vec_valid && vec_ready, and vec_data is latched into the shift register sreg. vec_ready=1 in IDLE, STROBE and DRAIN, and 0 in SHIFT.
- States:
  - IDLE: di=0, stb=0. On transfer, go to SHIFT with bitcnt=0.
  - SHIFT: for DIN_N cycles, di = sreg MSB and sreg shifts left. The first bit driven is vec_data[DIN_N-1]. When bitcnt == DIN_N-1, go to STROBE.
  - STROBE: one cycle, stb=1, di=0. The junk bit shifted in is flushed by the next vector.
    - Arms capture: capcnt=0, capture pending.
    - On transfer, go to SHIFT (back-to-back period DIN_N+1 cycles); otherwise go to DRAIN.
  - DRAIN: di=0, stb=0. On transfer, go to SHIFT (capture continues in parallel). When capture completes without a transfer, go to IDLE.
- Capture runs independently of the main FSM. In each of the DOUT_N cycles following the STROBE cycle, the block samples do_in at the clock edge and does cap <= {cap[DOUT_N-2:0], do_in}. The do_in value in the STROBE cycle itself is ignored.
- After DOUT_N samples, res_data <= cap and res_valid pulses for 1 cycle. The pulse comes DOUT_N+1 cycles after the STROBE cycle.
- res_first = first flag, and the flag then clears.
- Because DOUT_N <= DIN_N, a capture always completes before the next STROBE.
- Semantics: the strobe for vector k loads vector k and captures ROI output driven by vector k-1. Result k therefore reflects the state after vector k-1.
- Simultaneous events:
  - A transfer in the DRAIN cycle where capture completes goes to SHIFT, and res_valid still pulses.
  - res_valid is not back-pressured; the consumer must accept it.
- res_data holds its value between pulses.

Test Plan:
- Harness model: DIN_N=DOUT_N=8, harness regs init 0, roi dout=din (identity).
- Reset then one vector 0xA5:
  - di over the 8 SHIFT cycles = 1,0,1,0,0,1,0,1.
  - stb=1 in cycle 9 with di=0.
  - res_valid 9 cycles after stb, with res_data=0x00 and res_first=1.
- Back-to-back 0xA5, 0x3C, 0xFF with vec_valid held high:
  - stb period is 9 cycles.
  - Results are 0x00 (first), 0xA5, 0x3C.
  - vec_ready is high only in IDLE, STROBE and DRAIN cycles.
- vec_valid dropped after 0xA5, then 0x3C offered in the 3rd DRAIN cycle:
  - Accepted immediately and SHIFT starts next cycle.
  - The pending capture still returns 0x00 on time.
- 0x3C offered exactly in the DRAIN cycle where capture completes:
  - res_valid pulses and the FSM goes to SHIFT, not IDLE.
- rst_n asserted mid-SHIFT of 0x5A:
  - Outputs go to reset values immediately (asynchronously).
  - After release, vector 0x11 yields a first result with res_first=1.
- DOUT_N=4, DIN_N=8, vector 0xF0 followed by 0x00:
  - Second result is 0xF (top 4 bits of the identity output).
  - res_valid 5 cycles after the second stb.
